// File: rtl/image_pixel_fetch.sv
// image_pixel_fetch: maps a screen coordinate to an image-ROM word address and
// streams the returned pixel colour back in request order.
// Optional feature macro: TRANSPARENT_KEY_EN (pixels equal to KEY_COLOR report hit=0).
// The mem_addr register acts as the ROM's address register, so mem_q for an
// accepted request is sampled ROM_LAT cycles after acceptance.
`timescale 1ns/1ps
module image_pixel_fetch #(
  parameter int unsigned IMG_W      = 320,
  parameter int unsigned IMG_H      = 240,
  parameter int unsigned X_W        = 9,
  parameter int unsigned Y_W        = 8,
  parameter int unsigned NUM_FRAMES = 1,
  parameter int unsigned FRAME_W    = 1,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned COLOR_W    = 3,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned KEY_COLOR  = 0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [X_W-1:0]     x_origin,
  input  logic [Y_W-1:0]     y_origin,
  input  logic [FRAME_W-1:0] frame_sel,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COLOR_W-1:0] mem_q,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COLOR_W-1:0] pix_color,
  output logic               pix_hit
);

  localparam int unsigned DEPTH    = ROM_LAT + 2;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned FRAME_SZ = IMG_W * IMG_H;
  localparam logic [COLOR_W-1:0] KEY = COLOR_W'(KEY_COLOR);
`ifdef TRANSPARENT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic [ADDR_W-1:0]  mem_addr_q;
  logic [ROM_LAT-1:0] sb_valid_q, sb_hit_q;
  logic [COLOR_W-1:0] fifo_color_q [DEPTH];
  logic               fifo_hit_q   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d, credits_q, credits_d;
  logic               ready_q, ready_d;

  logic [X_W:0]       lx;
  logic [Y_W:0]       ly;
  logic               inb, accept, pop, wr_en, wr_hit;
  logic [COLOR_W-1:0] wr_color;
  logic [ADDR_W-1:0]  addr_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stage A: image-local coordinate, bounds test and ROM address
  always_comb begin
    lx     = {1'b0, x} - {1'b0, x_origin};
    ly     = {1'b0, y} - {1'b0, y_origin};
    inb    = !lx[X_W] && (32'(lx[X_W-1:0]) < IMG_W) &&
             !ly[Y_W] && (32'(ly[Y_W-1:0]) < IMG_H) &&
             (32'(frame_sel) < NUM_FRAMES);
    addr_c = ADDR_W'(frame_sel) * ADDR_W'(FRAME_SZ) +
             ADDR_W'(ly[Y_W-1:0]) * ADDR_W'(IMG_W) +
             ADDR_W'(lx[X_W-1:0]);
  end

  // Handshakes, FIFO write data and next-state for pointers and counters
  always_comb begin
    accept     = req_valid && ready_q;
    pop        = (fifo_cnt_q != '0) && pix_ready;
    wr_en      = sb_valid_q[ROM_LAT-1];
    wr_hit     = sb_hit_q[ROM_LAT-1] && !(KEY_EN && (mem_q == KEY));
    wr_color   = wr_hit ? mem_q : '0;
    wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    credits_d  = credits_q + CNT_W'(accept) - CNT_W'(pop);
    ready_d    = (32'(credits_d) < DEPTH);
  end

  // Address register, sideband pipeline, pointers and credit counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_addr_q <= '0;
      sb_valid_q <= '0;
      sb_hit_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      credits_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      if (accept && inb) mem_addr_q <= addr_c;
      sb_valid_q[0] <= accept;
      sb_hit_q[0]   <= accept && inb;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        sb_valid_q[i] <= sb_valid_q[i-1];
        sb_hit_q[i]   <= sb_hit_q[i-1];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      credits_q  <= credits_d;
      ready_q    <= ready_d;
    end
  end

  // Result storage; contents are only observed while the entry is valid
  always_ff @(posedge clock) begin
    if (wr_en) begin
      fifo_color_q[wr_ptr_q] <= wr_color;
      fifo_hit_q[wr_ptr_q]   <= wr_hit;
    end
  end

  // Output head, forced to zero while the FIFO is empty
  always_comb begin
    pix_valid = (fifo_cnt_q != '0);
    pix_color = pix_valid ? fifo_color_q[rd_ptr_q] : '0;
    pix_hit   = pix_valid ? fifo_hit_q[rd_ptr_q] : 1'b0;
    req_ready = ready_q;
    mem_addr  = mem_addr_q;
  end

endmodule

// File: tb/tb_image_pixel_fetch.sv
// Bench for image_pixel_fetch: instance A uses default geometry (ROM_LAT=1),
// instance B a 16x16 four-frame image with ROM_LAT=2. Both use KEY_COLOR=3.
// ROM model: q = addr[2:0], with the DUT's mem_addr register counted as the
// first ROM latency stage.
`timescale 1ns/1ps
module tb_image_pixel_fetch;

  localparam int KEY = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Instance A signals
  logic        a_req_valid, a_req_ready, a_pix_valid, a_pix_ready, a_pix_hit;
  logic [8:0]  a_x, a_ox;
  logic [7:0]  a_y, a_oy;
  logic [0:0]  a_frame;
  logic [16:0] a_mem_addr;
  logic [2:0]  a_mem_q, a_pix_color;

  // Instance B signals
  logic        b_req_valid, b_req_ready, b_pix_valid, b_pix_ready, b_pix_hit;
  logic [8:0]  b_x, b_ox;
  logic [7:0]  b_y, b_oy;
  logic [1:0]  b_frame;
  logic [9:0]  b_mem_addr;
  logic [2:0]  b_mem_q, b_pix_color, b_rom_r;

  image_pixel_fetch #(.KEY_COLOR(3)) dut_a (
    .clock(clk), .resetn(rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .x(a_x), .y(a_y), .x_origin(a_ox), .y_origin(a_oy), .frame_sel(a_frame),
    .mem_addr(a_mem_addr), .mem_q(a_mem_q), .pix_valid(a_pix_valid),
    .pix_ready(a_pix_ready), .pix_color(a_pix_color), .pix_hit(a_pix_hit));

  image_pixel_fetch #(.IMG_W(16), .IMG_H(16), .NUM_FRAMES(4), .FRAME_W(2),
                      .ADDR_W(10), .ROM_LAT(2), .KEY_COLOR(3)) dut_b (
    .clock(clk), .resetn(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .x(b_x), .y(b_y), .x_origin(b_ox), .y_origin(b_oy), .frame_sel(b_frame),
    .mem_addr(b_mem_addr), .mem_q(b_mem_q), .pix_valid(b_pix_valid),
    .pix_ready(b_pix_ready), .pix_color(b_pix_color), .pix_hit(b_pix_hit));

  // ROM models
  assign a_mem_q = a_mem_addr[2:0];
  always @(posedge clk) b_rom_r <= b_mem_addr[2:0];
  assign b_mem_q = b_rom_r;

  // Reference: {hit, colour} of a request from plain coordinate arithmetic
  function automatic logic [3:0] model(input int x, input int y, input int ox, input int oy,
                                       input int f, input int w, input int h, input int nf);
    int lx, ly, addr;
    lx = x - ox;
    ly = y - oy;
    if (lx < 0 || lx >= w || ly < 0 || ly >= h || f >= nf) return 4'b0000;
    addr = f * w * h + ly * w + lx;
`ifdef TRANSPARENT_KEY_EN
    if (addr % 8 == KEY) return 4'b0000;
`endif
    return {1'b1, 3'(addr % 8)};
  endfunction

  logic [3:0] a_exp[$], a_obs[$], b_exp[$], b_obs[$];
  int         a_pop_cyc[$];

  // Scoreboard capture at mid-cycle: expected on accept, observed on pop
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (a_req_valid && a_req_ready)
        a_exp.push_back(model(int'(a_x), int'(a_y), int'(a_ox), int'(a_oy), int'(a_frame), 320, 240, 1));
      if (a_pix_valid && a_pix_ready) begin
        a_obs.push_back({a_pix_hit, a_pix_color});
        a_pop_cyc.push_back(cyc);
      end
      if (b_req_valid && b_req_ready)
        b_exp.push_back(model(int'(b_x), int'(b_y), int'(b_ox), int'(b_oy), int'(b_frame), 16, 16, 4));
      if (b_pix_valid && b_pix_ready)
        b_obs.push_back({b_pix_hit, b_pix_color});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    a_exp.delete(); a_obs.delete(); a_pop_cyc.delete();
    b_exp.delete(); b_obs.delete();
  endtask

  task automatic wait_obs(input bit sel_b, input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((sel_b ? b_obs.size() : a_obs.size()) >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a_req_valid = 1'b0; a_pix_ready = 1'b1; a_x = '0; a_y = '0; a_ox = '0; a_oy = '0; a_frame = '0;
    b_req_valid = 1'b0; b_pix_ready = 1'b1; b_x = '0; b_y = '0; b_ox = '0; b_oy = '0; b_frame = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (a_pix_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid: got %b expected 0", a_pix_valid); end
    n_cmp++; if (a_pix_color !== 3'd0) begin n_err++; $display("FAIL rst_a_color: got %0d expected 0", a_pix_color); end
    n_cmp++; if (a_pix_hit !== 1'b0) begin n_err++; $display("FAIL rst_a_hit: got %b expected 0", a_pix_hit); end
    n_cmp++; if (a_mem_addr !== 17'd0) begin n_err++; $display("FAIL rst_a_addr: got %0d expected 0", a_mem_addr); end
    n_cmp++; if (b_pix_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_valid: got %b expected 0", b_pix_valid); end
    n_cmp++; if (b_mem_addr !== 10'd0) begin n_err++; $display("FAIL rst_b_addr: got %0d expected 0", b_mem_addr); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_a_ready: got %b expected 1", a_req_ready); end
    n_cmp++; if (b_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_b_ready: got %b expected 1", b_req_ready); end
    clear_q();
  endtask

  task automatic test_basic();
    tick();
    a_x = 9'd5; a_y = 8'd2; a_ox = '0; a_oy = '0; a_frame = '0; a_req_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b expected 1", a_req_ready); end
    tick();
    a_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_mem_addr !== 17'd645) begin n_err++; $display("FAIL basic_addr: got %0d expected 645", a_mem_addr); end
    n_cmp++; if (a_pix_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b expected 0", a_pix_valid); end
    @(negedge clk);
    n_cmp++; if (a_pix_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", a_pix_valid); end
    n_cmp++; if ({a_pix_hit, a_pix_color} !== 4'b1101) begin n_err++; $display("FAIL basic_pixel: got hit=%b color=%0d expected hit=1 color=5", a_pix_hit, a_pix_color); end
    repeat (3) @(negedge clk);
    clear_q();
  endtask

  task automatic test_key();
    logic [3:0] want;
    bit ok;
`ifdef TRANSPARENT_KEY_EN
    want = 4'b0000;
`else
    want = 4'b1011;
`endif
    tick();
    a_x = 9'd3; a_y = 8'd0; a_ox = '0; a_oy = '0; a_frame = '0; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    wait_obs(1'b0, 1, 10, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL key_timeout: got %0d results expected 1", a_obs.size()); end
    else begin
      n_cmp++; if (a_obs[0] !== want) begin n_err++; $display("FAIL key_pixel: got %b expected %b", a_obs[0], want); end
    end
    clear_q();
  endtask

  task automatic test_origin();
    bit ok;
    int xs[3] = '{115, 116, 99};
    int ys[3] = '{65, 65, 50};
    logic [3:0] want[3] = '{4'b1111, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      tick();
      b_x = 9'(xs[i]); b_y = 8'(ys[i]); b_ox = 9'd100; b_oy = 8'd50; b_frame = 2'd2; b_req_valid = 1'b1;
      tick();
      b_req_valid = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        n_cmp++; if (b_mem_addr !== 10'd767) begin n_err++; $display("FAIL origin_addr: got %0d expected 767", b_mem_addr); end
      end
      wait_obs(1'b1, i + 1, 10, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL origin_timeout_%0d: got %0d results expected %0d", i, b_obs.size(), i + 1); end
      else begin
        n_cmp++; if (b_obs[i] !== want[i]) begin n_err++; $display("FAIL origin_pixel_%0d: got %b expected %b", i, b_obs[i], want[i]); end
      end
    end
    clear_q();
  endtask

  task automatic test_back_to_back();
    bit ok, rdy_ok;
    int ox, oy, xv, yv;
    rdy_ok = 1'b1;
    a_pix_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      ox = int'($urandom_range(0, 100)); oy = int'($urandom_range(0, 40));
      xv = ox + int'($urandom_range(0, 330)); yv = oy + int'($urandom_range(0, 250));
      if (xv > 511) xv = 511;
      if (yv > 255) yv = 255;
      a_x = 9'(xv); a_y = 8'(yv); a_ox = 9'(ox); a_oy = 8'(oy);
      a_frame = 1'($urandom_range(0, 5) == 0);
      a_req_valid = 1'b1;
      @(negedge clk);
      if (!a_req_ready) rdy_ok = 1'b0;
    end
    tick();
    a_req_valid = 1'b0;
    n_cmp++; if (rdy_ok !== 1'b1) begin n_err++; $display("FAIL b2b_ready_held: got %b expected 1", rdy_ok); end
    wait_obs(1'b0, 40, 30, ok);
    n_cmp++; if (a_obs.size() != 40 || a_exp.size() != 40) begin n_err++; $display("FAIL b2b_count: got %0d/%0d expected 40", a_obs.size(), a_exp.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        n_cmp++; if (a_obs[i] !== a_exp[i]) begin n_err++; $display("FAIL b2b_pixel_%0d: got %b expected %b", i, a_obs[i], a_exp[i]); end
      end
      n_cmp++; if (a_pop_cyc[39] - a_pop_cyc[0] != 39) begin n_err++; $display("FAIL b2b_rate: got span %0d expected 39", a_pop_cyc[39] - a_pop_cyc[0]); end
    end
    clear_q();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [3:0] head;
    b_pix_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      b_ox = 9'($urandom_range(0, 300)); b_oy = 8'($urandom_range(0, 200));
      b_x = b_ox + 9'($urandom_range(0, 15)); b_y = b_oy + 8'($urandom_range(0, 15));
      b_frame = 2'($urandom_range(0, 3));
      b_req_valid = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (b_exp.size() != 4) begin n_err++; $display("FAIL bp_accepts: got %0d expected 4", b_exp.size()); end
    n_cmp++; if (b_req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b expected 0", b_req_ready); end
    head = {b_pix_hit, b_pix_color};
    tick();
    b_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({b_pix_hit, b_pix_color} !== head || b_pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_head_stable: got %b valid=%b expected %b valid=1", {b_pix_hit, b_pix_color}, b_pix_valid, head); end
    n_cmp++; if (b_exp.size() < 1 || head !== b_exp[0]) begin n_err++; $display("FAIL bp_head_value: got %b expected first of %0d queued", head, b_exp.size()); end
    tick();
    b_pix_ready = 1'b1;
    wait_obs(1'b1, 4, 20, ok);
    repeat (5) @(negedge clk);
    n_cmp++; if (b_obs.size() != 4) begin n_err++; $display("FAIL bp_drain_count: got %0d expected 4", b_obs.size()); end
    else if (b_exp.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (b_obs[i] !== b_exp[i]) begin n_err++; $display("FAIL bp_drain_%0d: got %b expected %b", i, b_obs[i], b_exp[i]); end
      end
    end
    clear_q();
  endtask

  task automatic test_random();
    bit ok;
    int xv, yv;
    for (int i = 0; i < 300; i++) begin
      tick();
      b_ox = 9'($urandom_range(0, 200)); b_oy = 8'($urandom_range(0, 200));
      xv = int'(b_ox) + int'($urandom_range(0, 20)) - 2;
      yv = int'(b_oy) + int'($urandom_range(0, 20)) - 2;
      if (xv < 0) xv = 0;
      if (yv < 0) yv = 0;
      b_x = 9'(xv); b_y = 8'(yv);
      b_frame = 2'($urandom_range(0, 3));
      b_req_valid = 1'($urandom_range(0, 1));
      b_pix_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    b_req_valid = 1'b0;
    b_pix_ready = 1'b1;
    @(negedge clk);
    wait_obs(1'b1, b_exp.size(), 50, ok);
    repeat (3) @(negedge clk);
    n_cmp++; if (b_obs.size() != b_exp.size() || b_exp.size() == 0) begin n_err++; $display("FAIL rand_count: got %0d expected %0d", b_obs.size(), b_exp.size()); end
    else begin
      for (int i = 0; i < b_exp.size(); i++) begin
        n_cmp++; if (b_obs[i] !== b_exp[i]) begin n_err++; $display("FAIL rand_pixel_%0d: got %b expected %b", i, b_obs[i], b_exp[i]); end
      end
    end
    clear_q();
  endtask

  task automatic test_reset_midstream();
    bit ok;
    a_pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      a_x = 9'($urandom_range(0, 300)); a_y = 8'($urandom_range(0, 200));
      a_ox = '0; a_oy = '0; a_frame = '0; a_req_valid = 1'b1;
    end
    tick();
    a_req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_pix_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 1", a_pix_valid); end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (a_pix_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_drop: got %b expected 0", a_pix_valid); end
    n_cmp++; if (a_pix_color !== 3'd0 || a_mem_addr !== 17'd0) begin n_err++; $display("FAIL mid_outputs: got color=%0d addr=%0d expected 0/0", a_pix_color, a_mem_addr); end
    repeat (2) @(negedge clk);
    clear_q();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (a_req_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b expected 1", a_req_ready); end
    a_pix_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (a_obs.size() != 0 || a_pix_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %0d results valid=%b expected 0", a_obs.size(), a_pix_valid); end
    tick();
    a_x = 9'd319; a_y = 8'd239; a_ox = '0; a_oy = '0; a_frame = '0; a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    wait_obs(1'b0, 1, 10, ok);
    n_cmp++; if (!ok || a_exp.size() != 1) begin n_err++; $display("FAIL mid_after_count: got %0d/%0d expected 1", a_obs.size(), a_exp.size()); end
    else begin
      n_cmp++; if (a_obs[0] !== a_exp[0]) begin n_err++; $display("FAIL mid_after_pixel: got %b expected %b", a_obs[0], a_exp[0]); end
    end
    clear_q();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key();
    test_origin();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
